// File: rtl/ysyx_22051013_axi_bus_scheduler_pkg.sv
// Shared widths, default AXI IDs and FSM state encodings for the AXI bus scheduler.
package ysyx_22051013_axi_bus_scheduler_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = 8;
    localparam int unsigned ID_W   = 5;
    localparam int unsigned RESP_W = 2;

    localparam logic [ID_W-1:0] DEF_IF_ID = 5'd1;
    localparam logic [ID_W-1:0] DEF_LS_ID = 5'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_ADDR = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    // Any non-OKAY response (SLVERR, DECERR, EXOKAY) is reported as an error.
    function automatic logic resp_err(input logic [RESP_W-1:0] resp);
        return |resp;
    endfunction

endpackage

// File: rtl/ysyx_22051013_rr_arb2.sv
// Two-way round-robin picker; the pointer moves only when the served request completes.
module ysyx_22051013_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic [1:0] grant
);

    // prio_q set means requester 1 wins a tie.
    logic prio_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (update) begin
            prio_q <= ~served;
        end
    end

    always_comb begin
        grant = req;
        if (req[0] && req[1]) begin
            grant = prio_q ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ysyx_22051013_axi_bus_scheduler.sv
// Schedules IF reads and LSU reads/writes onto one AXI master port.
// Optional watchdog: define YSYX_22051013_AXI_TIMEOUT_EN.
module ysyx_22051013_axi_bus_scheduler
    import ysyx_22051013_axi_bus_scheduler_pkg::*;
#(
    parameter logic [ID_W-1:0] IF_ID       = DEF_IF_ID,
    parameter logic [ID_W-1:0] LS_ID       = DEF_LS_ID,
    parameter int unsigned     TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_rerr,
    input  logic              ls_rreq,
    input  logic [ADDR_W-1:0] ls_raddr,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_rerr,
    input  logic              ls_wreq,
    input  logic [ADDR_W-1:0] ls_waddr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [STRB_W-1:0] ls_wstrb,
    output logic              ls_wdone,
    output logic              ls_werr,
    output logic [ID_W-1:0]   axi_aw_id,
    output logic [ADDR_W-1:0] axi_aw_addr,
    output logic              axi_aw_valid,
    input  logic              axi_aw_ready,
    output logic [DATA_W-1:0] axi_w_data,
    output logic [STRB_W-1:0] axi_w_strb,
    output logic              axi_w_valid,
    input  logic              axi_w_ready,
    input  logic [ID_W-1:0]   axi_b_id,
    input  logic [RESP_W-1:0] axi_b_resp,
    input  logic              axi_b_valid,
    output logic              axi_b_ready,
    output logic [ID_W-1:0]   axi_ar_id,
    output logic [ADDR_W-1:0] axi_ar_addr,
    output logic              axi_ar_valid,
    input  logic              axi_ar_ready,
    input  logic [ID_W-1:0]   axi_r_id,
    input  logic [DATA_W-1:0] axi_r_data,
    input  logic [RESP_W-1:0] axi_r_resp,
    input  logic              axi_r_valid,
    output logic              axi_r_ready
);

    logic [1:0]        r_state_q, r_state_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [ID_W-1:0]   r_id_q, r_id_d;
    logic              r_sel_q, r_sel_d;
    logic              r_done, r_err;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        rd_req, rd_grant;

    logic              if_rvalid_q, if_rvalid_d, if_rerr_q, if_rerr_d;
    logic              ls_rvalid_q, ls_rvalid_d, ls_rerr_q, ls_rerr_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;

    logic [1:0]        w_state_q, w_state_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0] w_strb_q, w_strb_d;
    logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic              aw_ok, w_ok;
    logic              ls_wdone_q, ls_wdone_d, ls_werr_q, ls_werr_d;

`ifdef YSYX_22051013_AXI_TIMEOUT_EN
    logic [31:0] r_cnt_q, w_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || r_state_q == R_IDLE) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= r_cnt_q + 32'd1;
        end
        if (rst || w_state_q == W_IDLE) begin
            w_cnt_q <= '0;
        end else begin
            w_cnt_q <= w_cnt_q + 32'd1;
        end
    end
`endif

    // A requester is held off during its own completion pulse, when it is still asserted.
    // LSU reads also wait for any write in progress or being requested.
    assign rd_req[0] = if_req && !if_rvalid_q;
    assign rd_req[1] = ls_rreq && !ls_rvalid_q && (w_state_q == W_IDLE) && !ls_wreq;

    ysyx_22051013_rr_arb2 u_rd_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (rd_req),
        .update (r_done),
        .served (r_sel_q),
        .grant  (rd_grant)
    );

    always_comb begin
        r_state_d   = r_state_q;
        r_addr_d    = r_addr_q;
        r_id_d      = r_id_q;
        r_sel_d     = r_sel_q;
        r_done      = 1'b0;
        r_err       = 1'b0;
        r_data      = '0;
        if_rvalid_d = 1'b0;
        if_rdata_d  = '0;
        if_rerr_d   = 1'b0;
        ls_rvalid_d = 1'b0;
        ls_rdata_d  = '0;
        ls_rerr_d   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (|rd_grant) begin
                    r_sel_d   = rd_grant[1];
                    r_addr_d  = rd_grant[1] ? ls_raddr : if_addr;
                    r_id_d    = rd_grant[1] ? LS_ID : IF_ID;
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (axi_ar_ready) r_state_d = R_DATA;
            end
            R_DATA: begin
                if (axi_r_valid && axi_r_id == r_id_q) begin
                    r_done    = 1'b1;
                    r_data    = axi_r_data;
                    r_err     = resp_err(axi_r_resp);
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
`ifdef YSYX_22051013_AXI_TIMEOUT_EN
        if (r_state_q != R_IDLE && !r_done && r_cnt_q == 32'(TIMEOUT_CYC - 1)) begin
            r_done    = 1'b1;
            r_data    = '0;
            r_err     = 1'b1;
            r_state_d = R_IDLE;
        end
`endif
        if (r_done) begin
            if (r_sel_q) begin
                ls_rvalid_d = 1'b1;
                ls_rdata_d  = r_data;
                ls_rerr_d   = r_err;
            end else begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = r_data;
                if_rerr_d   = r_err;
            end
        end
    end

    always_comb begin
        w_state_d  = w_state_q;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        ls_wdone_d = 1'b0;
        ls_werr_d  = 1'b0;
        aw_ok      = aw_done_q || (axi_aw_valid && axi_aw_ready);
        w_ok       = w_done_q || (axi_w_valid && axi_w_ready);
        case (w_state_q)
            W_IDLE: begin
                if (ls_wreq && !ls_wdone_q) begin
                    w_addr_d  = ls_waddr;
                    w_data_d  = ls_wdata;
                    w_strb_d  = ls_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                if (aw_ok && w_ok) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_RESP;
                end else begin
                    aw_done_d = aw_ok;
                    w_done_d  = w_ok;
                end
            end
            W_RESP: begin
                if (axi_b_valid && axi_b_id == LS_ID) begin
                    ls_wdone_d = 1'b1;
                    ls_werr_d  = resp_err(axi_b_resp);
                    w_state_d  = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
`ifdef YSYX_22051013_AXI_TIMEOUT_EN
        if (w_state_q != W_IDLE && !ls_wdone_d && w_cnt_q == 32'(TIMEOUT_CYC - 1)) begin
            ls_wdone_d = 1'b1;
            ls_werr_d  = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
            w_state_d  = W_IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= R_IDLE;
            r_addr_q    <= '0;
            r_id_q      <= '0;
            r_sel_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            if_rerr_q   <= 1'b0;
            ls_rvalid_q <= 1'b0;
            ls_rdata_q  <= '0;
            ls_rerr_q   <= 1'b0;
            w_state_q   <= W_IDLE;
            w_addr_q    <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            ls_wdone_q  <= 1'b0;
            ls_werr_q   <= 1'b0;
        end else begin
            r_state_q   <= r_state_d;
            r_addr_q    <= r_addr_d;
            r_id_q      <= r_id_d;
            r_sel_q     <= r_sel_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            if_rerr_q   <= if_rerr_d;
            ls_rvalid_q <= ls_rvalid_d;
            ls_rdata_q  <= ls_rdata_d;
            ls_rerr_q   <= ls_rerr_d;
            w_state_q   <= w_state_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            ls_wdone_q  <= ls_wdone_d;
            ls_werr_q   <= ls_werr_d;
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign if_rerr   = if_rerr_q;
    assign ls_rvalid = ls_rvalid_q;
    assign ls_rdata  = ls_rdata_q;
    assign ls_rerr   = ls_rerr_q;
    assign ls_wdone  = ls_wdone_q;
    assign ls_werr   = ls_werr_q;

    // Payloads read as zero whenever their valid is low.
    assign axi_ar_valid = (r_state_q == R_ADDR);
    assign axi_ar_id    = axi_ar_valid ? r_id_q : '0;
    assign axi_ar_addr  = axi_ar_valid ? r_addr_q : '0;
    assign axi_r_ready  = (r_state_q == R_DATA);

    assign axi_aw_valid = (w_state_q == W_ADDR) && !aw_done_q;
    assign axi_aw_id    = axi_aw_valid ? LS_ID : '0;
    assign axi_aw_addr  = axi_aw_valid ? w_addr_q : '0;
    assign axi_w_valid  = (w_state_q == W_ADDR) && !w_done_q;
    assign axi_w_data   = axi_w_valid ? w_data_q : '0;
    assign axi_w_strb   = axi_w_valid ? w_strb_q : '0;
    assign axi_b_ready  = (w_state_q == W_RESP);

endmodule
